reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Reset controller that drives the per-stage synchronous reset inputs of the datapath registers. It takes the board-level asynchronous reset and synchronises its deassertion. It then releases NUM_STAGES downstream reset lines one at a time, in fixed order, with a programmable gap between releases. A software-requested re-sequence lets firmware re-reset the whole datapath without touching the board reset.

## Interface
- NUM_STAGES, 4, number of sequenced reset outputs; legal range ≥1.
- GAP_CYCLES, 8, clock cycles between consecutive releases, and the hold time for a software reset; legal range 1..2^CNT_W.
- SYNC_DEPTH, 2, flops in the deassertion synchroniser; legal range ≥2.
- CNT_W, 8, gap-counter width.
- clk  input  1  single clock; all state is on its rising edge.
- reset  input  1  reset is asynchronous and active-low; assertion clears all state immediately, deassertion is synchronised internally.
- sw_reset_req  input  1  level request for a full re-sequence; sampled only in RUN.
- stage_rst_n  output  NUM_STAGES  active-low reset per datapath stage; bit 0 is released first.
- seq_done  output  1  high once all stages are released.
- seq_busy  output  1  high while any stage is held in reset.
- sw_reset_ack  output  1  one-cycle pulse when the software-reset hold phase ends.

## Operation
- Reset values (reset low, asynchronous):
  - stage_rst_n=0 (all bits), seq_done=0, seq_busy=1, sw_reset_ack=0.
  - Synchroniser chain=0, state=HOLD, cnt=0, idx=0.
- Synchroniser: SYNC_DEPTH-flop chain shifting in 1; sync_ok = last flop. Reset clears the chain asynchronously.
- States and transitions:
  - HOLD: waits for sync_ok=1, then goes to WAIT with cnt=0, idx=0.
  - WAIT: if cnt==GAP_CYCLES-1:
    - Set stage_rst_n[idx]=1 and clear cnt.
    - If idx==NUM_STAGES-1, go to RUN and set seq_done=1, seq_busy=0 on the same edge.
    - Otherwise increment idx and stay in WAIT.
  - WAIT, cnt below terminal: cnt++.
  - RUN: all outputs stable. If sw_reset_req=1, go to SW_ASSERT. On that edge stage_rst_n=0 (all bits), seq_done=0, seq_busy=1, cnt=0.
  - SW_ASSERT: cnt++ until cnt==GAP_CYCLES-1. On that edge, set sw_reset_ack=1 for exactly one cycle and go to WAIT with cnt=0, idx=0.
- stage_rst_n invariants:
  - Bits release in ascending order, at most one bit per edge.
  - A released bit stays high until reset or SW_ASSERT.
  - The vector is always of the form 0…01…1 (released bits are the low-order ones).
- sw_reset_req is ignored in HOLD, WAIT and SW_ASSERT, with no queuing. A request still high when RUN is re-entered triggers another re-sequence.
- Reset low in any state, including mid-WAIT or mid-SW_ASSERT, returns all outputs to reset values immediately, with no clock needed. A reset pulse shorter than one clock period has the same effect.
- No combinational path from any input to any output; all outputs are registered.

## Timing
- Edge numbering: the first rising clk edge after reset rises is edge 1.
- sync_ok=1 after edge SYNC_DEPTH. HOLD→WAIT at edge SYNC_DEPTH+1.
- Stage k releases at edge SYNC_DEPTH+1+(k+1)·GAP_CYCLES.
- seq_done rises at edge SYNC_DEPTH+1+NUM_STAGES·GAP_CYCLES. With defaults: stage 0 at edge 11, done at edge 35.
- Software request sampled high in RUN at edge E:
  - All stages asserted at edge E.
  - sw_reset_ack high from E+GAP_CYCLES to E+GAP_CYCLES+1.
  - Stage k released at E+(k+2)·GAP_CYCLES.
  - seq_done at E+(NUM_STAGES+1)·GAP_CYCLES. With defaults: ack at E+8, done at E+40.
- GAP_CYCLES=1: stages release on consecutive edges, and sw_reset_ack coincides with the SW_ASSERT exit edge E+1.

## Test plan
- Power-on, defaults: reset low 3 cycles, then high → stage_rst_n 0000→0001@11→0011@19→0111@27→1111@35; seq_done and seq_busy toggle at edge 35.
- Software reset: sw_reset_req 1-cycle pulse in RUN at edge E=50 → stage_rst_n=0000@50; ack pulse @58 only; 0001@66; 1111 and seq_done@90.
- Ignored request: sw_reset_req held high from edge 12 to edge 30 (during WAIT) → no change to the sequence, done at 35, no ack.
- Reset mid-sequence: reset low asynchronously between edges 20 and 21 → stage_rst_n=0000 and seq_busy=1 before edge 21; resequence restarts from edge 1 after release.
- Corner parameters NUM_STAGES=1, GAP_CYCLES=1, SYNC_DEPTH=3 → stage_rst_n[0] and seq_done rise at edge 5; a sw_reset_req at edge 10 produces ack@11 and done@12.
- Runt reset: 1 ns low pulse of reset while in RUN → immediate full clear and a complete resequence.

Source files
------------

// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronises board reset deassertion, then releases
// NUM_STAGES active-low stage resets in ascending order, GAP_CYCLES apart.
module reset_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int GAP_CYCLES = 8,
  parameter int SYNC_DEPTH = 2,
  parameter int CNT_W      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  sw_reset_req_i,
  output logic [NUM_STAGES-1:0] stage_rst_n_o,
  output logic                  seq_done_o,
  output logic                  seq_busy_o,
  output logic                  sw_reset_ack_o
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {S_HOLD, S_WAIT, S_RUN, S_SW_ASSERT} state_e;

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  sync_ok;
  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic [NUM_STAGES-1:0] stage_q;
  logic                  done_q, busy_q, ack_q;

  // Deassertion synchroniser; assertion still clears it asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_DEPTH-2:0], 1'b1};
  end

  assign sync_ok = sync_q[SYNC_DEPTH-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        S_HOLD: begin
          if (sync_ok) begin
            state_q <= S_WAIT;
            cnt_q   <= '0;
            idx_q   <= '0;
          end
        end
        S_WAIT: begin
          if (cnt_q == CNT_LAST) begin
            // Release only the current stage so the vector stays thermometer-coded.
            for (int i = 0; i < NUM_STAGES; i++)
              if (idx_q == IDX_W'(i)) stage_q[i] <= 1'b1;
            cnt_q <= '0;
            if (idx_q == IDX_LAST) begin
              state_q <= S_RUN;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (sw_reset_req_i) begin
            state_q <= S_SW_ASSERT;
            stage_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        S_SW_ASSERT: begin
          if (cnt_q == CNT_LAST) begin
            ack_q   <= 1'b1;
            state_q <= S_WAIT;
            cnt_q   <= '0;
            idx_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= S_HOLD;
      endcase
    end
  end

  assign stage_rst_n_o  = stage_q;
  assign seq_done_o     = done_q;
  assign seq_busy_o     = busy_q;
  assign sw_reset_ack_o = ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: edge-arithmetic model checked every cycle on the
// default instance, plus directed literal checks on default and corner instances.
module tb_reset_sequencer;
  localparam int N = 4, G = 8, D = 2;

  logic clk = 1'b0, rst_n = 1'b0, req = 1'b0;
  logic rst_c_n = 1'b0, req_c = 1'b0;
  logic [N-1:0] stage;
  logic done, busy, ack;
  logic [0:0] stage_c;
  logic done_c, busy_c, ack_c;
  int pass_cnt = 0, tot_cnt = 0;

  always #5 clk = ~clk;

  reset_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n), .sw_reset_req_i(req),
    .stage_rst_n_o(stage), .seq_done_o(done), .seq_busy_o(busy), .sw_reset_ack_o(ack)
  );

  reset_sequencer #(.NUM_STAGES(1), .GAP_CYCLES(1), .SYNC_DEPTH(3)) dutc (
    .clk_i(clk), .rst_ni(rst_c_n), .sw_reset_req_i(req_c),
    .stage_rst_n_o(stage_c), .seq_done_o(done_c), .seq_busy_o(busy_c), .sw_reset_ack_o(ack_c)
  );

  // Model: m_edge counts edges since reset release; m_start is the edge the
  // release countdown began; m_sw is the edge a software request was taken.
  int m_edge = 0, m_start = -1, m_sw = -1;

  function automatic int rel_cnt(int e, int s);
    int c;
    if (s < 0 || e < s) return 0;
    c = (e - s) / G;
    return (c > N) ? N : c;
  endfunction

  function automatic logic [N-1:0] therm(int c);
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) if (i < c) v[i] = 1'b1;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int e;
    if (!rst_n) begin
      m_edge  <= 0;
      m_start <= -1;
      m_sw    <= -1;
    end else begin
      e = m_edge + 1;
      m_edge <= e;
      if (m_start < 0 && e == D + 1) m_start <= D + 1;
      else if (rel_cnt(m_edge, m_start) == N && req) begin
        m_sw    <= e;
        m_start <= e + G;
      end
    end
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s @edge %0d: got %0h expected %0h", nm, m_edge, got, exp);
  endtask

  always @(negedge clk) begin : compare
    int c;
    logic a;
    c = rel_cnt(m_edge, m_start);
    a = (m_sw >= 0) && (m_edge == m_sw + G);
    chk("model", {25'd0, stage, done, busy, ack},
        {25'd0, therm(c), (c == N), (c != N), a});
  end

  task automatic lit(string nm, logic [N-1:0] s, logic d, logic b, logic a);
    chk(nm, {25'd0, stage, done, busy, ack}, {25'd0, s, d, b, a});
  endtask

  task automatic lit_c(string nm, logic s, logic d, logic b, logic a);
    chk(nm, {28'd0, stage_c, done_c, busy_c, ack_c}, {28'd0, s, d, b, a});
  endtask

  task automatic to_edge(int n);
    int guard = 0;
    while (m_edge < n && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (m_edge != n) begin
      tot_cnt++;
      $display("FAIL edge_wait: reached %0d wanted %0d", m_edge, n);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    lit("reset_vals", 4'b0000, 1'b0, 1'b1, 1'b0);
    lit_c("reset_vals_c", 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    rst_c_n = 1'b1;

    // Power-on sequence, corner instance and ignored request during WAIT
    to_edge(4);  lit_c("c_pre_rel", 1'b0, 1'b0, 1'b1, 1'b0);
    to_edge(5);  lit_c("c_rel", 1'b1, 1'b1, 1'b0, 1'b0);
    to_edge(9);  req_c = 1'b1;
    to_edge(10); lit("pre_stage0", 4'b0000, 1'b0, 1'b1, 1'b0);
                 lit_c("c_sw_assert", 1'b0, 1'b0, 1'b1, 1'b0);
                 req_c = 1'b0;
    to_edge(11); lit("stage0", 4'b0001, 1'b0, 1'b1, 1'b0);
                 lit_c("c_ack", 1'b0, 1'b0, 1'b1, 1'b1);
                 req = 1'b1;
    to_edge(12); lit_c("c_done", 1'b1, 1'b1, 1'b0, 1'b0);
    to_edge(19); lit("stage1", 4'b0011, 1'b0, 1'b1, 1'b0);
    to_edge(27); lit("stage2", 4'b0111, 1'b0, 1'b1, 1'b0);
    to_edge(30); req = 1'b0;
    to_edge(34); lit("pre_done", 4'b0111, 1'b0, 1'b1, 1'b0);
    to_edge(35); lit("done", 4'b1111, 1'b1, 1'b0, 1'b0);

    // Software reset sampled at edge 50
    to_edge(49); req = 1'b1;
    to_edge(50); lit("sw_assert", 4'b0000, 1'b0, 1'b1, 1'b0);
                 req = 1'b0;
    to_edge(57); lit("sw_pre_ack", 4'b0000, 1'b0, 1'b1, 1'b0);
    to_edge(58); lit("sw_ack", 4'b0000, 1'b0, 1'b1, 1'b1);
    to_edge(59); lit("sw_ack_end", 4'b0000, 1'b0, 1'b1, 1'b0);
    to_edge(66); lit("sw_stage0", 4'b0001, 1'b0, 1'b1, 1'b0);
    to_edge(89); lit("sw_pre_done", 4'b0111, 1'b0, 1'b1, 1'b0);
    to_edge(90); lit("sw_done", 4'b1111, 1'b1, 1'b0, 1'b0);

    // Request held across re-entry to RUN triggers a second re-sequence
    to_edge(99);  req = 1'b1;
    to_edge(140); lit("held_done1", 4'b1111, 1'b1, 1'b0, 1'b0);
    to_edge(141); lit("held_retrig", 4'b0000, 1'b0, 1'b1, 1'b0);
    to_edge(145); req = 1'b0;
    to_edge(149); lit("held_ack", 4'b0000, 1'b0, 1'b1, 1'b1);
    to_edge(181); lit("held_done2", 4'b1111, 1'b1, 1'b0, 1'b0);

    // Runt reset pulse while in RUN
    to_edge(200);
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    #1 lit("runt_clear", 4'b0000, 1'b0, 1'b1, 1'b0);
    to_edge(10); lit("runt_pre0", 4'b0000, 1'b0, 1'b1, 1'b0);
    to_edge(20); lit("runt_stage1", 4'b0011, 1'b0, 1'b1, 1'b0);

    // Reset asserted mid-WAIT, between edges 20 and 21
    #3 rst_n = 1'b0;
    #1 lit("mid_clear", 4'b0000, 1'b0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1 lit("mid_held", 4'b0000, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    to_edge(11); lit("mid_stage0", 4'b0001, 1'b0, 1'b1, 1'b0);
    to_edge(35); lit("mid_done", 4'b1111, 1'b1, 1'b0, 1'b0);
    to_edge(40); lit_c("c_final", 1'b1, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim did not finish");
    $fatal(1);
  end
endmodule
